// File: rtl/max_tracker.sv
// Windowed running-maximum tracker: captures the largest of WIN accepted samples and its position.
// Optional MAX_TRACKER_MIN_EN adds a matching running-minimum (min_val/min_idx).
module max_tracker #(
    parameter int WIDTH = 3,
    parameter int WIN   = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] max_val,
    output logic [IDX_W-1:0] max_idx,
    output logic             new_max,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state_dbg
`ifdef MAX_TRACKER_MIN_EN
    ,
    output logic [WIDTH-1:0] min_val,
    output logic [IDX_W-1:0] min_idx
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIN - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] count;
    logic             accept;

    // Handshake: a sample transfers on a cycle where in_valid and in_ready are both high.
    assign in_ready  = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            count   <= '0;
            max_val <= '0;
            max_idx <= '0;
            new_max <= 1'b0;
            done    <= 1'b0;
        end else begin
            new_max <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        // Strict compare keeps the first occurrence on ties.
                        if ((count == '0) || (in_data > max_val)) begin
                            max_val <= in_data;
                            max_idx <= count;
                            new_max <= 1'b1;
                        end
                        if (count == LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAX_TRACKER_MIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_val <= '0;
            min_idx <= '0;
        end else if (accept && ((count == '0) || (in_data < min_val))) begin
            min_val <= in_data;
            min_idx <= count;
        end
    end
`endif

endmodule

// File: tb/tb_max_tracker.sv
// Self-checking bench for max_tracker (WIDTH=3, WIN=4): directed scenarios plus random traffic vs a queue model.
module tb_max_tracker;

    localparam int WIDTH = 3;
    localparam int WIN   = 4;
    localparam int IDX_W = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic [WIDTH-1:0] max_val;
    logic [IDX_W-1:0] max_idx;
    logic             new_max;
    logic             done;
    logic             busy;
    logic [1:0]       state_dbg;
`ifdef MAX_TRACKER_MIN_EN
    logic [WIDTH-1:0] min_val;
    logic [IDX_W-1:0] min_idx;
`endif

    max_tracker #(.WIDTH(WIDTH), .WIN(WIN), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .max_val(max_val), .max_idx(max_idx), .new_max(new_max),
        .done(done), .busy(busy), .state_dbg(state_dbg)
`ifdef MAX_TRACKER_MIN_EN
        , .min_val(min_val), .min_idx(min_idx)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the accepted samples of the current window; max/min are recomputed by scanning.
    logic [WIDTH-1:0] win_q[$];
    int               m_phase = 0;  // 0 waiting for start, 1 collecting, 2 window complete
    logic [WIDTH-1:0] e_max = '0, e_min = '0;
    logic [IDX_W-1:0] e_idx = '0, e_min_idx = '0;
    logic             e_new = 1'b0, e_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            win_q.delete();
            e_max = '0; e_idx = '0; e_min = '0; e_min_idx = '0;
            e_new = 1'b0; e_done = 1'b0;
        end else begin
            e_new  = 1'b0;
            e_done = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    win_q.delete();
                end
                1: if (in_valid) begin
                    int best, lo;
                    win_q.push_back(in_data);
                    best = 0;
                    lo   = 0;
                    for (int i = 1; i < win_q.size(); i++) begin
                        if (win_q[i] > win_q[best]) best = i;
                        if (win_q[i] < win_q[lo]) lo = i;
                    end
                    e_max     = win_q[best];
                    e_idx     = best[IDX_W-1:0];
                    e_new     = (best == win_q.size() - 1);
                    e_min     = win_q[lo];
                    e_min_idx = lo[IDX_W-1:0];
                    if (win_q.size() == WIN) begin
                        e_done  = 1'b1;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_phase == 1));
        chk("busy",     int'(busy),     int'(m_phase != 0));
        chk("done",     int'(done),     int'(e_done));
        chk("new_max",  int'(new_max),  int'(e_new));
        chk("max_val",  int'(max_val),  int'(e_max));
        chk("max_idx",  int'(max_idx),  int'(e_idx));
`ifdef MAX_TRACKER_MIN_EN
        chk("min_val",  int'(min_val),  int'(e_min));
        chk("min_idx",  int'(min_idx),  int'(e_min_idx));
`endif
    end

    // ---------------- driver tasks ----------------
    int nm_cnt;
    int done_cnt;

    task automatic cyc(input logic st, input logic v, input logic [WIDTH-1:0] d);
        start    = st;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        nm_cnt   += int'(new_max);
        done_cnt += int'(done);
    endtask

    // Start cycle presents a bogus valid sample (7) that must not be accepted.
    task automatic feed(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                        input logic [WIDTH-1:0] s2, input logic [WIDTH-1:0] s3,
                        input int gap, input logic hold);
        logic [WIDTH-1:0] s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        nm_cnt   = 0;
        done_cnt = 0;
        cyc(1'b1, 1'b1, 3'd7);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < ((i == 0) ? 0 : gap); g++)
                cyc(hold, 1'b0, WIDTH'($urandom));
            cyc(hold, 1'b1, s[i]);
        end
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_max_val",  int'(max_val),  0);
        chk("rst_max_idx",  int'(max_idx),  0);
        chk("rst_new_max",  int'(new_max),  0);
        chk("rst_done",     int'(done),     0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_in_ready", int'(in_ready), 0);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Scenario 1: async reset before any clock edge.
        async_reset();
        cyc(1'b0, 1'b0, '0);

        // Scenario 2: 010,100,011,110 back-to-back.
        feed(3'b010, 3'b100, 3'b011, 3'b110, 0, 1'b0);
        chk("s2_done_now",   int'(done),     1);
        chk("s2_max_val",    int'(max_val),  6);
        chk("s2_max_idx",    int'(max_idx),  3);
        chk("s2_ready_done", int'(in_ready), 0);
        chk("s2_model_max",  int'(e_max),    6);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk("s2_newmax_cnt", nm_cnt,   3);
        chk("s2_done_cnt",   done_cnt, 1);

        // Scenario 3: ties keep first occurrence.
        feed(3'b101, 3'b101, 3'b011, 3'b101, 0, 1'b0);
        chk("s3_max_val", int'(max_val), 5);
        chk("s3_max_idx", int'(max_idx), 0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk("s3_newmax_cnt", nm_cnt, 1);

        // Scenario 4: 2-cycle gaps, start held high through RUN and DONE.
        feed(3'b001, 3'b000, 3'b111, 3'b010, 2, 1'b1);
        chk("s4_done_now", int'(done),    1);
        chk("s4_max_val",  int'(max_val), 7);
        chk("s4_max_idx",  int'(max_idx), 2);
        cyc(1'b1, 1'b0, '0);
        chk("s4_busy_idle", int'(busy), 0);
        cyc(1'b0, 1'b0, '0);
        chk("s4_idle_stays", int'(busy), 0);
        chk("s4_done_cnt", done_cnt, 1);

        // Scenario 5: reset mid-window, then a fresh window.
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 3'b110);
        cyc(1'b0, 1'b1, 3'b111);
        async_reset();
        chk("s5_model_phase", m_phase, 0);
        cyc(1'b0, 1'b1, 3'b111);
        chk("s5_no_restart", int'(busy), 0);
        feed(3'b000, 3'b001, 3'b000, 3'b000, 0, 1'b0);
        chk("s5_max_val", int'(max_val), 1);
        chk("s5_max_idx", int'(max_idx), 1);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);

`ifdef MAX_TRACKER_MIN_EN
        // Scenario 6: minimum tracking.
        feed(3'b100, 3'b000, 3'b011, 3'b000, 0, 1'b0);
        chk("s6_min_val", int'(min_val), 0);
        chk("s6_min_idx", int'(min_idx), 1);
        chk("s6_max_val", int'(max_val), 4);
        chk("s6_max_idx", int'(max_idx), 0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
`endif

        // Random traffic: starts, valid gaps, occasional mid-cycle resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0)
                async_reset();
            else
                cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), WIDTH'($urandom));
        end
        cyc(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/max_tracker.md
# max_tracker

Windowed running-maximum tracker placed directly downstream of the 3-bit greater-than comparator.
- Accepts a stream of unsigned samples over a valid/ready handshake.
- Compares each accepted sample against the stored maximum using strict greater-than.
- After a fixed window of samples, reports the window maximum and its position with a one-cycle done pulse, then returns to idle.

## Interface
- WIDTH, 3, sample width in bits; equals the comparator operand width.
- WIN, 8, number of accepted samples per window; legal range 2 ≤ WIN ≤ 2^IDX_W.
- IDX_W, 3, width of the sample-index outputs and the internal sample counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state and outputs.
- start  input  1  begins a new window; sampled only in IDLE.
- in_valid  input  1  in_data carries a sample this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  WIDTH  unsigned sample.
- max_val  output  WIDTH  largest sample in the current or last window.
- max_idx  output  IDX_W  window position (0-based) of max_val.
- new_max  output  1  one-cycle pulse: the last accepted sample became the maximum.
- done  output  1  one-cycle pulse: the window is complete and max_val/max_idx are final.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 moves to RUN and clears the counter.
  - max_val and max_idx keep the previous window's result.
- RUN:
  - in_ready=1, busy=1.
  - Accept is in_valid && in_ready.
  - start is ignored.
- First accept of a window (count==0): load max_val=in_data, max_idx=0, pulse new_max.
- Later accepts:
  - If in_data > max_val (unsigned, strict), load max_val=in_data and max_idx=count, and pulse new_max.
  - Equal or smaller samples leave the maximum unchanged, so the first occurrence wins ties.
- The counter increments on every accept.
- On the accept where count==WIN-1, go to DONE.
- DONE:
  - Lasts exactly one cycle, with done=1, in_ready=0, busy=1.
  - start is ignored.
  - Then go to IDLE.
- Cycles with in_valid=0 in RUN do not advance the counter. Gaps of any length are legal.
- Reset values: state=IDLE, counter=0, max_val=0, max_idx=0, new_max=0, done=0, busy=0, in_ready=0.

## Timing
- in_ready and busy decode combinationally from the state register. Every other output is registered.
- Throughput is one sample per cycle while in_valid is held high.
- new_max is high during the cycle following the clock edge that accepted the qualifying sample. max_val and max_idx update on that same edge.
- done is high during the cycle following the edge that accepted sample WIN-1.
- A window with back-to-back samples:
  - start is sampled at edge 0.
  - Samples are accepted at edges 1 through WIN.
  - done is high after edge WIN.
  - IDLE is reached after edge WIN+1.
- start is sampled only in IDLE, so start held high through DONE has no effect until IDLE. The earliest restart is at edge WIN+2.
- in_ready is 0 in IDLE. A sample presented in the same cycle as start is not accepted.
- rst asserted at any time, including mid-window, forces reset values immediately without waiting for a clock edge. The partial window is discarded, and the next window requires a fresh start.

## Configuration
- MAX_TRACKER_MIN_EN defined:
  - Adds outputs min_val (WIDTH) and min_idx (IDX_W), with reset values 0.
  - On the first accept, load min_val=in_data and min_idx=0.
  - On later accepts, load them when in_data < min_val (strict); ties keep the first occurrence.
  - Both outputs are final when done is high.
  - new_max is unaffected by minimum updates.
- MAX_TRACKER_MIN_EN undefined: the min ports and min logic are absent and the remaining behaviour is identical.

## Test plan
All scenarios use WIDTH=3 and WIN=4.

1. Assert rst asynchronously mid-cycle -> immediately max_val=000, max_idx=0, new_max=0, done=0, busy=0, in_ready=0.
2. Pulse start, then feed 010, 100, 011, 110 back-to-back -> new_max pulses after samples 0, 1 and 3; done pulses once after the 4th; final max_val=110, max_idx=3; in_ready=0 during DONE.
3. Feed 101, 101, 011, 101 -> new_max pulses only after sample 0; final max_val=101, max_idx=0.
4. Feed 001, 000, 111, 010 with in_valid low for 2 cycles between samples -> the counter advances only on accepts; done comes exactly one cycle after the 4th accept; max_val=111, max_idx=2. Drive start high during RUN and DONE -> no effect.
5. Pulse start, accept 110 and 111, then assert rst -> all outputs 0 and state IDLE. Pulse start, feed 000, 001, 000, 000 -> max_val=001, max_idx=1.
6. With MAX_TRACKER_MIN_EN defined, feed 100, 000, 011, 000 -> min_val=000, min_idx=1, max_val=100, max_idx=0.
